// File: rtl/decodifica_movimentos_serial.sv
// Parses ASCII move bytes from the UART into 3-bit move codes for the move RAM, terminates the
// list with code 000 and answers with a one-byte ACK ('K') or NAK ('E').
module decodifica_movimentos_serial #(
  parameter int unsigned MAX_MOV = 480,
  parameter int unsigned N_ADDR  = 9,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [7:0]        rx_dado,
  input  logic              rx_pronto,
  input  logic              tx_ocupado,
  output logic [2:0]        movimento,
  output logic              we_movimento,
  output logic              conta_addr,
  output logic              zera_addr,
  output logic [7:0]        tx_dado,
  output logic              tx_partida,
  output logic              pronto,
  output logic              erro,
  output logic [N_ADDR-1:0] n_mov,
  output logic [3:0]        db_estado
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [N_ADDR-1:0] NMovLast    = N_ADDR'(MAX_MOV - 1);

  localparam logic [3:0] Inicial    = 4'd0;
  localparam logic [3:0] Zera       = 4'd1;
  localparam logic [3:0] EsperaByte = 4'd2;
  localparam logic [3:0] Decodifica = 4'd3;
  localparam logic [3:0] Escreve    = 4'd4;
  localparam logic [3:0] Conta      = 4'd5;
  localparam logic [3:0] EscreveFim = 4'd6;
  localparam logic [3:0] Erro       = 4'd7;
  localparam logic [3:0] Envia      = 4'd8;
  localparam logic [3:0] EsperaTx   = 4'd9;
  localparam logic [3:0] Final      = 4'd10;

  logic [3:0]        state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [N_ADDR-1:0] n_mov_q, n_mov_d;
  logic              erro_q, erro_d;
  logic [7:0]        tx_dado_q, tx_dado_d;
  logic [2:0]        mov_q, mov_d;
  logic              we_q, we_d;
  logic              conta_q, conta_d;
  logic              zera_q, zera_d;
  logic              partida_q, partida_d;
  logic              pronto_q, pronto_d;
  logic              is_code, is_fim, is_ignora;

  always_comb begin
    is_code   = (byte_q >= 8'h31) && (byte_q <= 8'h37);
    is_fim    = (byte_q == 8'h23);
    is_ignora = (byte_q == 8'h0A) || (byte_q == 8'h0D) || (byte_q == 8'h20);
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    cnt_d     = '0;
    n_mov_d   = n_mov_q;
    erro_d    = erro_q;
    tx_dado_d = tx_dado_q;
    case (state_q)
      Inicial, Final: begin
        if (iniciar) begin
          state_d = Zera;
          erro_d  = 1'b0;
          n_mov_d = '0;
        end
      end
      Zera: state_d = EsperaByte;
      EsperaByte: begin
        if (rx_pronto) begin
          byte_d  = rx_dado;
          state_d = Decodifica;
        end else if (cnt_q == TimeoutLast) begin
          state_d = Erro;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      Decodifica: begin
        if (is_code)        state_d = Escreve;
        else if (is_fim)    state_d = EscreveFim;
        else if (is_ignora) state_d = EsperaByte;
        else                state_d = Erro;
      end
      Escreve: state_d = Conta;
      Conta: begin
        n_mov_d = n_mov_q + 1'b1;
        // Last usable slot is reserved for the end marker.
        state_d = (n_mov_d == NMovLast) ? EscreveFim : EsperaByte;
      end
      EscreveFim: begin
        tx_dado_d = 8'h4B;
        state_d   = Envia;
      end
      Erro: begin
        erro_d    = 1'b1;
        tx_dado_d = 8'h45;
        state_d   = Envia;
      end
      Envia: if (!tx_ocupado) state_d = EsperaTx;
      // First cycle here carries the start pulse; the UART cannot be busy yet.
      EsperaTx: if (!partida_q && !tx_ocupado) state_d = Final;
      default: state_d = Inicial;
    endcase
  end

  always_comb begin
    we_d      = (state_d == Escreve) || (state_d == EscreveFim) || (state_d == Erro);
    mov_d     = (state_d == Escreve) ? byte_q[2:0] : 3'b000;
    conta_d   = (state_d == Conta);
    zera_d    = (state_d == Zera);
    pronto_d  = (state_d == Final);
    partida_d = (state_q == Envia) && (state_d == EsperaTx);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= Inicial;
      byte_q    <= '0;
      cnt_q     <= '0;
      n_mov_q   <= '0;
      erro_q    <= 1'b0;
      tx_dado_q <= '0;
      mov_q     <= '0;
      we_q      <= 1'b0;
      conta_q   <= 1'b0;
      zera_q    <= 1'b0;
      partida_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      n_mov_q   <= n_mov_d;
      erro_q    <= erro_d;
      tx_dado_q <= tx_dado_d;
      mov_q     <= mov_d;
      we_q      <= we_d;
      conta_q   <= conta_d;
      zera_q    <= zera_d;
      partida_q <= partida_d;
      pronto_q  <= pronto_d;
    end
  end

  assign movimento    = mov_q;
  assign we_movimento = we_q;
  assign conta_addr   = conta_q;
  assign zera_addr    = zera_q;
  assign tx_dado      = tx_dado_q;
  assign tx_partida   = partida_q;
  assign pronto       = pronto_q;
  assign erro         = erro_q;
  assign n_mov        = n_mov_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_decodifica_movimentos_serial.sv
// Bench for decodifica_movimentos_serial: directed cases plus random byte streams checked against
// a list-level model of the move parser, an external address counter and a UART transmitter.
module tb_decodifica_movimentos_serial;

  localparam int unsigned MaxMov  = 8;
  localparam int unsigned Timeout = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [7:0] rx_dado;
  logic       rx_pronto;
  logic       tx_ocupado = 1'b0;
  logic [2:0] movimento;
  logic       we_movimento;
  logic       conta_addr;
  logic       zera_addr;
  logic [7:0] tx_dado;
  logic       tx_partida;
  logic       pronto;
  logic       erro;
  logic [8:0] n_mov;
  logic [3:0] db_estado;

  decodifica_movimentos_serial #(
    .MAX_MOV(MaxMov),
    .N_ADDR (9),
    .TIMEOUT(Timeout)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .rx_dado     (rx_dado),
    .rx_pronto   (rx_pronto),
    .tx_ocupado  (tx_ocupado),
    .movimento   (movimento),
    .we_movimento(we_movimento),
    .conta_addr  (conta_addr),
    .zera_addr   (zera_addr),
    .tx_dado     (tx_dado),
    .tx_partida  (tx_partida),
    .pronto      (pronto),
    .erro        (erro),
    .n_mov       (n_mov),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Observed traffic: RAM writes (with the address an external counter would hold) and TX bytes.
  int         addr_ctr = 0;
  int         wr_addr[$];
  logic [2:0] wr_code[$];
  logic [7:0] tx_q[$];
  int         conta_cnt = 0;
  int         overlap_cnt = 0;
  int         busy_left = 0;
  logic       force_busy = 1'b0;

  always @(negedge clock) begin
    if (we_movimento === 1'b1) begin
      wr_addr.push_back(addr_ctr);
      wr_code.push_back(movimento);
    end
    if (zera_addr === 1'b1) addr_ctr = 0;
    if (conta_addr === 1'b1) begin
      addr_ctr++;
      conta_cnt++;
    end
    if ((int'(we_movimento === 1'b1) + int'(conta_addr === 1'b1) + int'(zera_addr === 1'b1) +
         int'(tx_partida === 1'b1)) > 1) overlap_cnt++;
    if (tx_partida === 1'b1) begin
      tx_q.push_back(tx_dado);
      busy_left = 3;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_ocupado = force_busy || (busy_left > 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_dado   = b;
    rx_pronto = 1'b1;
    @(negedge clock);
    rx_pronto = 1'b0;
    tick(gap - 1);
  endtask

  task automatic wait_pronto(input string tag);
    int n = 0;
    while (pronto !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".pronto"}, 32'(pronto), 32'd1);
  endtask

  // Reference model: what the move list should look like for a byte stream.
  logic [7:0] seq[$];
  logic [2:0] exp_w[$];
  int         exp_nm;
  logic       exp_err;
  logic [7:0] exp_tx;
  int         bw, bt, bc;

  task automatic model();
    bit done = 0;
    exp_w.delete();
    exp_nm  = 0;
    exp_err = 1'b0;
    exp_tx  = 8'h00;
    foreach (seq[i]) begin
      if (done) continue;
      if (seq[i] >= 8'h31 && seq[i] <= 8'h37) begin
        exp_w.push_back(3'(seq[i] - 8'h30));
        exp_nm++;
        if (exp_nm == int'(MaxMov) - 1) begin
          exp_w.push_back(3'd0);
          exp_tx = 8'h4B;
          done   = 1;
        end
      end else if (seq[i] == 8'h23) begin
        exp_w.push_back(3'd0);
        exp_tx = 8'h4B;
        done   = 1;
      end else if (seq[i] inside {8'h0A, 8'h0D, 8'h20}) begin
        continue;
      end else begin
        exp_w.push_back(3'd0);
        exp_err = 1'b1;
        exp_tx  = 8'h45;
        done    = 1;
      end
    end
    // No terminator: the idle timeout closes the list as an error.
    if (!done) begin
      exp_w.push_back(3'd0);
      exp_err = 1'b1;
      exp_tx  = 8'h45;
    end
  endtask

  task automatic begin_case(input string tag);
    model();
    bw = wr_code.size();
    bt = tx_q.size();
    bc = conta_cnt;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    chk({tag, ".zera"}, 32'(zera_addr), 32'd1);
    chk({tag, ".erro_clr"}, 32'(erro), 32'd0);
    tick(1);
  endtask

  task automatic end_case(input string tag);
    wait_pronto(tag);
    tick(2);
    chk({tag, ".nwr"}, wr_code.size() - bw, exp_w.size());
    foreach (exp_w[i]) begin
      if (bw + i < wr_code.size()) begin
        chk($sformatf("%s.addr%0d", tag, i), wr_addr[bw + i], i);
        chk($sformatf("%s.code%0d", tag, i), 32'(wr_code[bw + i]), 32'(exp_w[i]));
      end
    end
    chk({tag, ".n_mov"}, 32'(n_mov), exp_nm);
    chk({tag, ".erro"}, 32'(erro), 32'(exp_err));
    chk({tag, ".conta"}, conta_cnt - bc, exp_nm);
    chk({tag, ".ntx"}, tx_q.size() - bt, 1);
    if (tx_q.size() > bt) chk({tag, ".tx"}, 32'(tx_q[bt]), 32'(exp_tx));
  endtask

  task automatic run_case(input string tag);
    begin_case(tag);
    foreach (seq[i]) send(seq[i], $urandom_range(4, 12));
    end_case(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         len;
    reset     = 1'b0;
    iniciar   = 1'b0;
    rx_dado   = 8'h00;
    rx_pronto = 1'b0;
    tick(3);
    chk("reset.outs", {movimento, we_movimento, conta_addr, zera_addr, tx_dado, tx_partida,
                       pronto, erro, n_mov, db_estado}, 32'd0);
    reset = 1'b1;
    tick(2);
    chk("reset.idle", 32'(db_estado), 32'd0);

    // T1 with the 2-cycle rx_pronto -> we latency and conta one cycle later.
    seq = {8'h31, 8'h33, 8'h37, 8'h23};
    begin_case("T1");
    rx_dado   = 8'h31;
    rx_pronto = 1'b1;
    @(negedge clock);
    rx_pronto = 1'b0;
    chk("T1.lat1_we", 32'(we_movimento), 32'd0);
    @(negedge clock);
    chk("T1.lat2_we", 32'(we_movimento), 32'd1);
    chk("T1.lat2_mov", 32'(movimento), 32'd1);
    @(negedge clock);
    chk("T1.lat3_conta", 32'(conta_addr), 32'd1);
    chk("T1.lat3_we", 32'(we_movimento), 32'd0);
    @(negedge clock);
    send(8'h33, 5);
    send(8'h37, 4);
    send(8'h23, 6);
    end_case("T1");
    chk("T1.pronto_hold", 32'(pronto), 32'd1);

    seq = {8'h32, 8'h0D, 8'h0A, 8'h20, 8'h35, 8'h23};
    run_case("T2");
    seq = {8'h34, 8'h58};
    run_case("T3");
    seq = {8'h23};
    run_case("empty");
    seq = {8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31};
    run_case("T4");
    seq = {8'h36};
    run_case("T5");

    for (int k = 0; k < 14; k++) begin
      seq.delete();
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 19))
          0, 1, 2:  b = 8'h20 - 8'(($urandom_range(0, 2) == 0) ? 22 : 0);
          3:        b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
          4:        b = 8'($urandom_range(0, 255));
          default:  b = 8'h31 + 8'($urandom_range(0, 6));
        endcase
        seq.push_back(b);
      end
      if ($urandom_range(0, 4) != 0) seq.push_back(8'h23);
      run_case($sformatf("rnd%0d", k));
    end

    // T6: synchronous reset in mid-list, then a byte before iniciar must be dropped.
    seq = {8'h33};
    model();
    begin_case("T6");
    send(8'h33, 5);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("T6.reset_outs", {movimento, we_movimento, conta_addr, zera_addr, tx_dado, tx_partida,
                          pronto, erro, n_mov, db_estado}, 32'd0);
    bw = wr_code.size();
    send(8'h35, 8);
    chk("T6.rx_dropped", wr_code.size() - bw, 0);
    chk("T6.still_idle", 32'(db_estado), 32'd0);

    // Start pulse must wait while the transmitter is busy.
    force_busy = 1'b1;
    seq = {8'h23};
    begin_case("T6b");
    send(8'h23, 4);
    tick(20);
    chk("T6b.no_partida", tx_q.size() - bt, 0);
    chk("T6b.in_envia", 32'(db_estado), 32'd8);
    force_busy = 1'b0;
    end_case("T6b");

    chk("excl.outputs", overlap_cnt, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
